// File: rtl/axil_config_register_bank.sv
// AXI4-Lite configuration/status register bank: UPSTAT, IRQ block, control registers, saturating counters.
// Optional macro CRF_CNT_SNAPSHOT_EN: reading CNT[0] latches a coherent shadow copy of all counters.
module axil_config_register_bank #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int NUM_CTRL       = 4,
    parameter int NUM_CNT        = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               s_axi_awvalid,
    output logic                               s_axi_awready,
    input  logic [AXI_ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic [2:0]                         s_axi_awprot,
    input  logic                               s_axi_wvalid,
    output logic                               s_axi_wready,
    input  logic [AXI_DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]        s_axi_wstrb,
    output logic                               s_axi_bvalid,
    input  logic                               s_axi_bready,
    output logic [1:0]                         s_axi_bresp,
    input  logic                               s_axi_arvalid,
    output logic                               s_axi_arready,
    input  logic [AXI_ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic [2:0]                         s_axi_arprot,
    output logic                               s_axi_rvalid,
    input  logic                               s_axi_rready,
    output logic [AXI_DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                         s_axi_rresp,
    input  logic                               pl_wrt,
    input  logic [1:0]                         pl_wdata,
    output logic                               pl_wbusy,
    output logic                               up_start,
    output logic                               up_end,
    output logic [NUM_CTRL*AXI_DATA_WIDTH-1:0] ctrl_regs,
    input  logic                               cnt_run,
    input  logic [NUM_CNT-1:0]                 cnt_inc,
    output logic                               interrupt
);

    localparam int W         = AXI_DATA_WIDTH;
    localparam int SW        = AXI_DATA_WIDTH / 8;
    localparam int IA        = AXI_ADDR_WIDTH - 2;
    localparam int CTRL_BASE = 3;
    localparam int CNT_BASE  = 3 + NUM_CTRL;

    localparam logic [IA-1:0] IDX_UPSTAT   = IA'(0);
    localparam logic [IA-1:0] IDX_IRQ_EN   = IA'(1);
    localparam logic [IA-1:0] IDX_IRQ_STAT = IA'(2);
    localparam logic [1:0]    RESP_OKAY    = 2'b00;
    localparam logic [1:0]    RESP_SLVERR  = 2'b10;
    localparam logic [W-1:0]  CNT_MAX      = '1;

    logic          aw_held, w_held;
    logic [IA-1:0] aw_idx;
    logic [W-1:0]  w_data;
    logic [SW-1:0] w_strb;
    logic [W-1:0]  wr_mask;
    logic          commit, wr_ok, pl_accept;

    logic [1:0]    upstat, irq_en, irq_stat;
    logic [1:0]    stat_set, stat_clr;
    logic          start_q, end_q, start_rise, end_rise, sat_any;
    logic [W-1:0]  ctrl_q [NUM_CTRL];
    logic [W-1:0]  cnt_q  [NUM_CNT];

    logic [IA-1:0] ar_idx;
    logic          ar_hs;
    logic [W-1:0]  rd_data;
    logic          rd_err;

    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign commit    = aw_held && w_held && !s_axi_bvalid;
    assign wr_ok     = aw_idx < IA'(CNT_BASE);
    // Busy covers every cycle an address is held, so a commit to UPSTAT always beats the PL port.
    assign pl_wbusy  = aw_held;
    assign pl_accept = pl_wrt && !pl_wbusy;

    assign up_start   = upstat[0];
    assign up_end     = upstat[1];
    assign start_rise = upstat[0] && !start_q;
    assign end_rise   = upstat[1] && !end_q;

    assign ar_idx = s_axi_araddr[AXI_ADDR_WIDTH-1:2];
    assign ar_hs  = s_axi_arvalid && s_axi_arready;

    always_comb begin
        wr_mask = '0;
        for (int b = 0; b < SW; b++) wr_mask[b*8 +: 8] = {8{w_strb[b]}};
    end

    always_comb begin
        sat_any = 1'b0;
        for (int j = 0; j < NUM_CNT; j++)
            if (!start_rise && cnt_run && cnt_inc[j] && cnt_q[j] == (CNT_MAX - W'(1)))
                sat_any = 1'b1;
    end

    assign stat_set = {sat_any, end_rise};
    assign stat_clr = (commit && aw_idx == IDX_IRQ_STAT) ? (w_data[1:0] & wr_mask[1:0]) : 2'b00;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl_out
            assign ctrl_regs[gi*W +: W] = ctrl_q[gi];
        end
    endgenerate

    // Write channel: AW and W captured independently, committed together.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= 2'b00;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_idx        <= '0;
            w_data        <= '0;
            w_strb        <= '0;
        end else begin
            s_axi_awready <= s_axi_awvalid && !aw_held && !s_axi_awready && !s_axi_bvalid;
            s_axi_wready  <= s_axi_wvalid && !w_held && !s_axi_wready && !s_axi_bvalid;
            if (s_axi_awvalid && s_axi_awready) begin
                aw_held <= 1'b1;
                aw_idx  <= s_axi_awaddr[AXI_ADDR_WIDTH-1:2];
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_held <= 1'b1;
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end
            if (commit) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
        end
    end

    // Register file, edge detectors, counters and interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            upstat    <= '0;
            irq_en    <= '0;
            irq_stat  <= '0;
            interrupt <= 1'b0;
            start_q   <= 1'b0;
            end_q     <= 1'b0;
            for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= '0;
            for (int j = 0; j < NUM_CNT; j++)  cnt_q[j]  <= '0;
        end else begin
            start_q <= upstat[0];
            end_q   <= upstat[1];
            if (commit && aw_idx == IDX_UPSTAT)
                upstat <= (upstat & ~wr_mask[1:0]) | (w_data[1:0] & wr_mask[1:0]);
            else if (pl_accept)
                upstat <= pl_wdata;
            if (commit && aw_idx == IDX_IRQ_EN)
                irq_en <= (irq_en & ~wr_mask[1:0]) | (w_data[1:0] & wr_mask[1:0]);
            // Set is OR'ed after the clear so a same-cycle event is never lost.
            irq_stat  <= (irq_stat & ~stat_clr) | stat_set;
            interrupt <= |(irq_stat & irq_en);
            for (int i = 0; i < NUM_CTRL; i++)
                if (commit && aw_idx == IA'(CTRL_BASE + i))
                    ctrl_q[i] <= (ctrl_q[i] & ~wr_mask) | (w_data & wr_mask);
            for (int j = 0; j < NUM_CNT; j++) begin
                if (start_rise)
                    cnt_q[j] <= '0;
                else if (cnt_run && cnt_inc[j] && cnt_q[j] != CNT_MAX)
                    cnt_q[j] <= cnt_q[j] + W'(1);
            end
        end
    end

`ifdef CRF_CNT_SNAPSHOT_EN
    logic [W-1:0] shadow_q [NUM_CNT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NUM_CNT; j++) shadow_q[j] <= '0;
        end else if (ar_hs && ar_idx == IA'(CNT_BASE)) begin
            for (int j = 0; j < NUM_CNT; j++) shadow_q[j] <= cnt_q[j];
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b1;
        if (ar_idx == IDX_UPSTAT) begin
            rd_data[1:0] = upstat;
            rd_err       = 1'b0;
        end
        if (ar_idx == IDX_IRQ_EN) begin
            rd_data[1:0] = irq_en;
            rd_err       = 1'b0;
        end
        if (ar_idx == IDX_IRQ_STAT) begin
            rd_data[1:0] = irq_stat;
            rd_err       = 1'b0;
        end
        for (int i = 0; i < NUM_CTRL; i++)
            if (ar_idx == IA'(CTRL_BASE + i)) begin
                rd_data = ctrl_q[i];
                rd_err  = 1'b0;
            end
        for (int j = 0; j < NUM_CNT; j++)
            if (ar_idx == IA'(CNT_BASE + j)) begin
`ifdef CRF_CNT_SNAPSHOT_EN
                rd_data = (j == 0) ? cnt_q[j] : shadow_q[j];
`else
                rd_data = cnt_q[j];
`endif
                rd_err  = 1'b0;
            end
    end

    // Read channel: data and response registered at the AR handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= 2'b00;
        end else begin
            s_axi_arready <= s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;
            if (ar_hs) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_err ? '0 : rd_data;
                s_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axil_config_register_bank.sv
// Directed bench: a 32-bit instance plus an 8-bit lockstep instance whose counters saturate quickly.
module tb_axil_config_register_bank;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
    logic [31:0] awaddr = 0, araddr = 0, wdata = 0;
    logic [3:0]  wstrb = 0;
    logic [2:0]  awprot = 0, arprot = 0;
    logic        pl_wrt = 0, cnt_run = 0;
    logic [1:0]  pl_wdata = 0;
    logic [3:0]  cnt_inc = 0;

    logic         awready, wready, bvalid, arready, rvalid, pl_wbusy, up_start, up_end, interrupt;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [127:0] ctrl_regs;

    logic         awready_8, wready_8, bvalid_8, arready_8, rvalid_8, pl_wbusy_8, up_start_8, up_end_8, interrupt_8;
    logic [1:0]   bresp_8, rresp_8;
    logic [7:0]   rdata_8;
    logic [31:0]  ctrl_regs_8;

    axil_config_register_bank dut (
        .clk(clk), .rst(rst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awprot(awprot),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arprot(arprot),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .pl_wrt(pl_wrt), .pl_wdata(pl_wdata), .pl_wbusy(pl_wbusy),
        .up_start(up_start), .up_end(up_end), .ctrl_regs(ctrl_regs),
        .cnt_run(cnt_run), .cnt_inc(cnt_inc), .interrupt(interrupt)
    );

    axil_config_register_bank #(.AXI_DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready_8), .s_axi_awaddr(awaddr), .s_axi_awprot(awprot),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready_8), .s_axi_wdata(wdata[7:0]), .s_axi_wstrb(wstrb[0]),
        .s_axi_bvalid(bvalid_8), .s_axi_bready(bready), .s_axi_bresp(bresp_8),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready_8), .s_axi_araddr(araddr), .s_axi_arprot(arprot),
        .s_axi_rvalid(rvalid_8), .s_axi_rready(rready), .s_axi_rdata(rdata_8), .s_axi_rresp(rresp_8),
        .pl_wrt(pl_wrt), .pl_wdata(pl_wdata), .pl_wbusy(pl_wbusy_8),
        .up_start(up_start_8), .up_end(up_end_8), .ctrl_regs(ctrl_regs_8),
        .cnt_run(cnt_run), .cnt_inc(cnt_inc), .interrupt(interrupt_8)
    );

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] er, input int aw_dly);
        exp_t e;
        bit   ad = 0, wd = 0, ah, wh;
        int   k = 0;
        sb.push_back({er, 32'h0});
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; wvalid = 1;
        if (aw_dly == 0) awvalid = 1;
        while (!(ad && wd) && k < 40) begin
            ah = awvalid && awready;
            wh = wvalid && wready;
            @(posedge clk); #1;
            if (ah) begin awvalid = 0; ad = 1; end
            if (wh) begin wvalid = 0; wd = 1; end
            @(negedge clk);
            k++;
            if (k == aw_dly && !ad) awvalid = 1;
        end
        k = 0;
        while (!bvalid && k < 40) begin @(negedge clk); k++; end
        awvalid = 0; wvalid = 0;
        e = sb.pop_front();
        chk({tag, "_bvalid"}, {ad, wd, bvalid}, 3'b111);
        chk({tag, "_bresp"}, bresp, e.resp);
        chk({tag, "_bresp8"}, bresp_8, e.resp);
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input string tag, input logic [31:0] a, input logic [1:0] er,
                            input logic [31:0] ed, output logic [7:0] d8);
        exp_t e;
        bit   done = 0, h;
        int   k = 0;
        sb.push_back({er, ed});
        @(negedge clk);
        araddr = a; arvalid = 1;
        while (!done && k < 40) begin
            h = arvalid && arready;
            @(posedge clk); #1;
            if (h) begin arvalid = 0; done = 1; end
            @(negedge clk);
            k++;
        end
        k = 0;
        while (!rvalid && k < 40) begin @(negedge clk); k++; end
        arvalid = 0;
        e = sb.pop_front();
        chk({tag, "_rvalid"}, {done, rvalid}, 2'b11);
        chk(tag, {rresp, rdata}, {e.resp, e.data});
        d8 = rdata_8;
        @(posedge clk); #1;
    endtask

    task automatic pl_write(input logic [1:0] v);
        @(negedge clk);
        chk("pl_idle_busy", pl_wbusy, 1'b0);
        pl_wrt = 1; pl_wdata = v;
        @(posedge clk); #1;
        pl_wrt = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [7:0] d8;
        exp_t e;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata,
                              pl_wbusy, up_start, up_end, interrupt}, '0);
        chk("reset_ctrl", ctrl_regs, '0);
        chk("reset_dut8", {awready_8, wready_8, bvalid_8, bresp_8, arready_8, rvalid_8, rresp_8, rdata_8,
                           pl_wbusy_8, up_start_8, up_end_8, interrupt_8, ctrl_regs_8}, '0);
        rst = 0;

        // W arrives three cycles before AW
        axi_write("w_before_aw", 32'hC, 32'h3, 4'hF, 2'b00, 3);
        chk("ctrl0_port", ctrl_regs[31:0], 32'h3);
        axi_read("rd_ctrl0", 32'hC, 2'b00, 32'h3, d8);

        axi_write("wr_ctrl1", 32'h10, 32'hAABBCCDD, 4'hF, 2'b00, 0);
        axi_write("wr_ctrl1_strb", 32'h10, 32'h11223344, 4'h2, 2'b00, 0);
        axi_read("rd_ctrl1", 32'h10, 2'b00, 32'hAABB33DD, d8);
        chk("ctrl1_port", ctrl_regs[63:32], 32'hAABB33DD);

        axi_write("wr_unmapped", 32'h100, 32'hFFFFFFFF, 4'hF, 2'b10, 0);
        axi_read("rd_unmapped", 32'h100, 2'b10, 32'h0, d8);
        axi_write("wr_cnt0", 32'h1C, 32'h12345678, 4'hF, 2'b10, 0);
        axi_read("rd_cnt0_untouched", 32'h1C, 2'b00, 32'h0, d8);
        axi_read("rd_ctrl0_kept", 32'hC, 2'b00, 32'h3, d8);

        // Interrupt from up_end edge
        axi_write("wr_irq_en", 32'h4, 32'h1, 4'hF, 2'b00, 0);
        pl_write(2'b10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("irq_asserted", {up_end, interrupt, interrupt_8}, 3'b111);
        pl_write(2'b00);
        axi_write("w1c_first", 32'h8, 32'h1, 4'hF, 2'b00, 0);
        chk("irq_dropped", interrupt, 1'b0);

        // W1C commit in the same cycle as a fresh up_end edge: set wins
        sb.push_back({2'b00, 32'h0});
        @(negedge clk);
        awaddr = 32'h8; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(negedge clk);
        chk("coin_ready", {awready, wready, pl_wbusy}, 3'b110);
        pl_wrt = 1; pl_wdata = 2'b10;
        @(negedge clk);
        awvalid = 0; wvalid = 0; pl_wrt = 0;
        chk("coin_busy", pl_wbusy, 1'b1);
        @(negedge clk);
        e = sb.pop_front();
        chk("coin_bvalid", bvalid, 1'b1);
        chk("coin_bresp", bresp, e.resp);
        @(posedge clk); #1;
        axi_read("rd_irq_stat_kept", 32'h8, 2'b00, 32'h1, d8);
        chk("irq_still_high", interrupt, 1'b1);
        axi_write("w1c_second", 32'h8, 32'h1, 4'hF, 2'b00, 0);
        chk("irq_cleared", interrupt, 1'b0);
        axi_read("rd_irq_stat_zero", 32'h8, 2'b00, 32'h0, d8);

        // Counters: start edge clears, 5 increments
        pl_write(2'b01);
        @(posedge clk);
        @(negedge clk);
        cnt_run = 1; cnt_inc = 4'b0001;
        repeat (5) @(posedge clk);
        #1 cnt_inc = 4'b0000;
        axi_read("rd_cnt0_five", 32'h1C, 2'b00, 32'd5, d8);
        chk("cnt0_five_8", d8, 8'd5);
        axi_read("rd_cnt1_zero", 32'h20, 2'b00, 32'd0, d8);
        pl_write(2'b00);
        pl_write(2'b01);
        @(posedge clk); #1;
        axi_read("rd_cnt0_restart", 32'h1C, 2'b00, 32'd0, d8);

        // AXI write to UPSTAT while PL tries to write
        sb.push_back({2'b00, 32'h0});
        @(negedge clk);
        awaddr = 32'h0; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(negedge clk);
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        chk("cont_busy", pl_wbusy, 1'b1);
        pl_wrt = 1; pl_wdata = 2'b10;
        @(negedge clk);
        pl_wrt = 0;
        e = sb.pop_front();
        chk("cont_bvalid", bvalid, 1'b1);
        chk("cont_bresp", bresp, e.resp);
        @(posedge clk); #1;
        axi_read("rd_upstat_axi", 32'h0, 2'b00, 32'h1, d8);
        chk("cont_up_pins", {up_start, up_end}, 2'b10);

        // Saturation: the 8-bit instance clamps at 0xFF and flags IRQ_STAT[1]
        @(negedge clk);
        cnt_inc = 4'b0010;
        repeat (300) @(posedge clk);
        #1 cnt_inc = 4'b0000;
        axi_read("rd_cnt1_300", 32'h20, 2'b00, 32'd300, d8);
        chk("cnt1_sat_8", d8, 8'hFF);
        axi_read("rd_irq_stat_nosat", 32'h8, 2'b00, 32'h0, d8);
        chk("irq_stat_sat_8", d8, 8'h02);
        axi_write("wr_irq_en_both", 32'h4, 32'h3, 4'hF, 2'b00, 0);
        @(posedge clk); #1;
        chk("sat_interrupt", {interrupt, interrupt_8}, 2'b01);

        // Reset with a write response pending
        bready = 0;
        axi_write("wr_ctrl2_pending", 32'h14, 32'h55, 4'hF, 2'b00, 0);
        chk("b_pending", bvalid, 1'b1);
        @(negedge clk);
        rst = 1;
        @(posedge clk); #1;
        chk("midrst_outputs", {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata,
                               pl_wbusy, up_start, up_end, interrupt, interrupt_8, bvalid_8}, '0);
        chk("midrst_ctrl", ctrl_regs, '0);
        @(negedge clk);
        rst = 0; bready = 1;
        axi_read("rd_irq_en_reset", 32'h4, 2'b00, 32'h0, d8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
